// File: rtl/uart_tx_cfg_if.sv
// FIFO-side handshake of the UART transmitter: show-ahead head word, empty flag, pop strobe.
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 fifo_empty;
    logic                 fifo_read;

    modport master (
        output data_in,
        output fifo_empty,
        input  fifo_read
    );

    modport slave (
        input  data_in,
        input  fifo_empty,
        output fifo_read
    );
endinterface

// File: rtl/uart_tx_cfg.sv
// Parameterised UART transmitter fed from a show-ahead FIFO.
// Frame = start bit, DATA_BITS LSB first, optional parity, STOP_BITS stop bits; back-to-back capable.
module uart_tx_cfg #(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_tx_cfg_if.slave  fifo,
    output logic          transmit_wire,
    output logic          state_busy,
    output logic          tx_done
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQ / BAUD;
    localparam int CW = $clog2(CYCLES_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CYC  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit computed once when the word is latched; odd mode inverts the XOR.
    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY_MODE == 2) ? ~(^d) : (^d);
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cyc;
    logic [CW-1:0]        w_cyc_nxt;
    logic [BW-1:0]        r_bit;
    logic [BW-1:0]        w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_parity;
    logic                 w_parity_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_bit_end;
    logic                 w_last_stop;
    logic                 w_load;

    // Bit-boundary and pop strobes shared by the FSM and datapath.
    always_comb begin
        w_bit_end   = (r_cyc == LAST_CYC);
        w_last_stop = (r_state == S_STOP) && w_bit_end && (r_bit == LAST_STOP);
        w_load      = ((r_state == S_IDLE) || w_last_stop) && !fifo.fifo_empty;
    end

    assign fifo.fifo_read = w_load;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!fifo.fifo_empty) w_state_nxt = S_START;
                else                  w_state_nxt = S_IDLE;
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
                else           w_state_nxt = S_START;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit == LAST_DATA))
                    w_state_nxt = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                else
                    w_state_nxt = S_DATA;
            end
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
                else           w_state_nxt = S_PARITY;
            end
            S_STOP: begin
                if (w_last_stop) w_state_nxt = fifo.fifo_empty ? S_IDLE : S_START;
                else             w_state_nxt = S_STOP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counters, shift register and the line value for the next cycle.
    always_comb begin
        w_cyc_nxt    = r_cyc;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_tx_nxt     = 1'b1;

        if (w_load || (r_state == S_IDLE) || w_bit_end) w_cyc_nxt = {CW{1'b0}};
        else                                           w_cyc_nxt = r_cyc + CW'(1);

        // Bit index restarts whenever the state changes, so it serves both DATA and STOP.
        if (w_state_nxt != r_state)
            w_bit_nxt = {BW{1'b0}};
        else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP)))
            w_bit_nxt = r_bit + BW'(1);
        else
            w_bit_nxt = r_bit;

        if (w_load) begin
            w_shift_nxt  = fifo.data_in;
            w_parity_nxt = f_parity(fifo.data_in);
        end else if ((r_state == S_DATA) && w_bit_end) begin
            w_shift_nxt  = r_shift >> 1;
        end else begin
            w_shift_nxt  = r_shift;
        end

        case (w_state_nxt)
            S_IDLE:   w_tx_nxt = 1'b1;
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_parity_nxt;
            S_STOP:   w_tx_nxt = 1'b1;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cyc    <= {CW{1'b0}};
            r_bit    <= {BW{1'b0}};
            r_shift  <= {DATA_BITS{1'b0}};
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_last_stop;
        end
    end

    assign transmit_wire = r_tx;
    assign state_busy    = r_busy;
    assign tx_done       = r_done;

endmodule
